// File: rtl/parity_frame_ctrl_pkg.sv
// Shared types for the parity frame controller: FSM state encoding and default width.
package parity_pkg;

  localparam int LEN_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } state_e;

endpackage

// File: rtl/parity_frame_ctrl_if.sv
// Frame control, nibble input and parity result signals of the parity frame controller.
interface parity_frame_ctrl_if import parity_pkg::*; #(
  parameter int LEN_W = LEN_W_DEF
) ();

  logic             start;
  logic [LEN_W-1:0] len;
  logic             odd;
  logic             abort;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_data;
  logic             out_valid;
  logic             out_ready;
  logic             parity;
  logic             busy;
  logic [LEN_W-1:0] count;

  modport master (
    output start, len, odd, abort, in_valid, in_data, out_ready,
    input  in_ready, out_valid, parity, busy, count
  );

  modport slave (
    input  start, len, odd, abort, in_valid, in_data, out_ready,
    output in_ready, out_valid, parity, busy, count
  );

endinterface

// File: rtl/parity_frame_ctrl_nibble_parity.sv
// Combinational XOR reduction of one 4-bit nibble.
module nibble_parity (
  input  logic [3:0] nib,
  output logic       par
);

  assign par = ^nib;

endmodule

// File: rtl/parity_frame_ctrl.sv
// Accumulates parity over a frame of len nibbles and presents one result (even/odd mode).
// Result appears the cycle after the last accept; abort returns to IDLE from any busy state.
module parity_frame_ctrl import parity_pkg::*; #(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  parity_frame_ctrl_if.slave  bus
);

  state_e           state_q, state_d;
  logic             acc_q, acc_d;
  logic             odd_q, odd_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] cnt_inc;
  logic             nib_par;
  logic             accept;

  nibble_parity u_nibble_parity (
    .nib (bus.in_data),
    .par (nib_par)
  );

  assign cnt_inc = cnt_q + LEN_W'(1);

  // Abort masks both handshakes so nothing is transferred in the cancel cycle.
  always_comb begin
    bus.in_ready  = (state_q == RUN) && !bus.abort;
    bus.out_valid = (state_q == OUT) && !bus.abort;
    bus.parity    = (state_q == OUT) ? (acc_q ^ odd_q) : 1'b0;
    bus.busy      = (state_q != IDLE);
    bus.count     = cnt_q;
  end

  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    odd_d   = odd_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          odd_d = bus.odd;
          acc_d = 1'b0;
          cnt_d = '0;
          if (bus.len != '0) begin
            len_d   = bus.len;
            state_d = RUN;
          end else begin
            state_d = OUT;
          end
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (accept) begin
          acc_d = acc_q ^ nib_par;
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = OUT;
          end
        end
      end
      OUT: begin
        if (bus.abort || bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= 1'b0;
      odd_q   <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      odd_q   <= odd_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Directed bench for parity_frame_ctrl; expected results are queued at frame start and checked at the handshake.
module tb_parity_frame_ctrl;

  typedef struct {
    logic        par;
    logic [31:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  parity_frame_ctrl_if #(.LEN_W(4)) bus ();

  parity_frame_ctrl #(.LEN_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_parity"},    32'(bus.parity),    32'd0);
    chk({tag, "_busy"},      32'(bus.busy),      32'd0);
    chk({tag, "_count"},     32'(bus.count),     32'd0);
  endtask

  task automatic begin_frame(input int l, input logic o, input bit do_push,
                             input logic p, input int c);
    exp_t e;
    bus.start = 1'b1;
    bus.len   = 4'(l);
    bus.odd   = o;
    if (do_push) begin
      e.par = p;
      e.cnt = 32'(c);
      sb.push_back(e);
    end
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic feed(input logic [3:0] d, input int gap);
    logic [31:0] cnt_before;
    cnt_before = 32'(bus.count);
    for (int i = 0; i < gap; i++) begin
      bus.in_valid = 1'b0;
      cyc();
    end
    if (gap > 0) begin
      chk("count_hold_no_valid", 32'(bus.count), cnt_before);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    #1;
    chk("in_ready_run", 32'(bus.in_ready), 32'd1);
    cyc();
    bus.in_valid = 1'b0;
  endtask

  task automatic finish_frame(input string tag, input int hold, input logic start_in_hs);
    exp_t e;
    chk({tag, "_out_valid_rise"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_in_ready_out"},   32'(bus.in_ready),  32'd0);
    n_cmp++;
    assert (sb.size() != 0) else begin
      n_err++;
      $error("FAIL %s_sb_empty: observed 0 entries, expected at least 1", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      for (int i = 0; i < hold; i++) begin
        bus.out_ready = 1'b0;
        cyc();
        chk({tag, "_out_valid_hold"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_parity_hold"},    32'(bus.parity),    32'(e.par));
      end
      bus.out_ready = 1'b1;
      if (start_in_hs) begin
        bus.start = 1'b1;
        bus.len   = 4'd2;
        bus.odd   = 1'b1;
      end
      #1;
      chk({tag, "_parity"}, 32'(bus.parity), 32'(e.par));
      chk({tag, "_count"},  32'(bus.count),  e.cnt);
      cyc();
      bus.out_ready = 1'b0;
      chk({tag, "_idle_busy"},      32'(bus.busy),      32'd0);
      chk({tag, "_idle_out_valid"}, 32'(bus.out_valid), 32'd0);
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.len       = 4'd0;
    bus.odd       = 1'b0;
    bus.abort     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 4'd0;
    bus.out_ready = 1'b0;
    cyc();
    cyc();
    chk_idle_zero("reset");
    reset = 1'b0;
    cyc();

    // len=3 even: 0001,0011,0111 -> parity 0, count 3
    begin_frame(3, 1'b0, 1'b1, 1'b0, 3);
    chk("A_busy", 32'(bus.busy), 32'd1);
    feed(4'b0001, 0);
    feed(4'b0011, 0);
    chk("A_no_early_valid", 32'(bus.out_valid), 32'd0);
    feed(4'b0111, 0);
    finish_frame("A", 0, 1'b0);

    // same frame, odd mode -> parity 1
    begin_frame(3, 1'b1, 1'b1, 1'b1, 3);
    feed(4'b0001, 0);
    feed(4'b0011, 0);
    feed(4'b0111, 0);
    finish_frame("B", 0, 1'b0);

    // zero-length odd frame goes straight to OUT
    begin_frame(0, 1'b1, 1'b1, 1'b1, 0);
    finish_frame("C", 0, 1'b0);

    // gaps on input and a stalled consumer
    begin_frame(2, 1'b0, 1'b1, 1'b1, 2);
    feed(4'b1000, 0);
    feed(4'b0000, 3);
    finish_frame("D", 5, 1'b0);

    // abort after two accepts; the aborted cycle offers a nibble that must be refused
    begin_frame(4, 1'b0, 1'b0, 1'b0, 0);
    feed(4'b0101, 0);
    feed(4'b0110, 0);
    bus.abort    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 4'b0001;
    #1;
    chk("E_abort_in_ready", 32'(bus.in_ready), 32'd0);
    cyc();
    bus.in_valid = 1'b0;
    chk("E_abort_busy",      32'(bus.busy),      32'd0);
    chk("E_abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("E_abort_count",     32'(bus.count),     32'd2);
    // abort still high in IDLE must not block the next start
    begin_frame(1, 1'b0, 1'b1, 1'b0, 1);
    bus.abort = 1'b0;
    chk("E2_busy", 32'(bus.busy), 32'd1);
    chk("E2_count_cleared", 32'(bus.count), 32'd0);
    feed(4'b1111, 0);
    finish_frame("E2", 0, 1'b0);

    // maximum length: fifteen 0001 nibbles -> parity 1, count 15
    begin_frame(15, 1'b0, 1'b1, 1'b1, 15);
    for (int i = 0; i < 15; i++) begin
      feed(4'b0001, 0);
    end
    finish_frame("MAX", 0, 1'b0);

    // start held through the handshake is ignored there, then taken in IDLE
    begin_frame(1, 1'b0, 1'b1, 1'b1, 1);
    feed(4'b0001, 0);
    finish_frame("F", 0, 1'b1);
    chk("F_count_held_idle", 32'(bus.count), 32'd1);
    sb.push_back('{par: 1'b1, cnt: 32'd2});
    cyc();
    bus.start = 1'b0;
    chk("F_start_taken_busy", 32'(bus.busy),  32'd1);
    chk("F_start_taken_count", 32'(bus.count), 32'd0);
    feed(4'b0001, 0);
    feed(4'b0001, 0);
    chk("G_out_valid", 32'(bus.out_valid), 32'd1);
    chk("G_parity",    32'(bus.parity),    32'(sb[0].par));
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk_idle_zero("G_reset_in_out");
    void'(sb.pop_front());

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/parity_frame_ctrl.md
PARITY_FRAME_CTRL -- requirements
Module: parity_frame_ctrl

Interface
REQ-001 SHALL have parameter: LEN_W, 4, width of frame-length input and nibble counter.
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  begin a frame, sampled only in IDLE.
REQ-005 SHALL have port: len  input  LEN_W  frame length in nibbles, latched on accepted start.
REQ-006 SHALL have port: odd  input  1  parity mode, latched on accepted start: 0 = even, 1 = odd.
REQ-007 SHALL have port: abort  input  1  synchronous frame cancel.
REQ-008 SHALL have port: in_valid  input  1  in_data valid.
REQ-009 SHALL have port: in_ready  output  1  controller accepts a nibble this cycle.
REQ-010 SHALL have port: in_data  input  4  data nibble.
REQ-011 SHALL have port: out_valid  output  1  parity result valid.
REQ-012 SHALL have port: out_ready  input  1  consumer accepts the result.
REQ-013 SHALL have port: parity  output  1  frame parity bit.
REQ-014 SHALL have port: busy  output  1  high in RUN and OUT.
REQ-015 SHALL have port: count  output  LEN_W  nibbles accepted in the current frame.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, RUN, OUT.
REQ-017 SHALL, in IDLE with start=1 and len!=0: latch len and odd, clear accumulator and count, go to RUN.
REQ-018 SHALL, in IDLE with start=1 and len==0: latch odd, clear accumulator, go directly to OUT.
REQ-019 SHALL drive in_ready=1 only in RUN; a nibble is accepted when in_valid and in_ready are both 1.
REQ-020 SHALL, on each accepted nibble: accumulator <= accumulator XOR (XOR-reduce of in_data); count <= count+1.
REQ-021 SHALL go from RUN to OUT on the cycle the len-th nibble is accepted; out_valid rises the next cycle.
REQ-022 SHALL drive out_valid=1 only in OUT, with parity = accumulator XOR latched odd.
REQ-023 SHALL hold out_valid and parity stable in OUT until out_ready=1; the handshake cycle returns the FSM to IDLE.
REQ-024 SHALL ignore start in RUN and OUT, including start in the OUT handshake cycle; a new frame needs at least one IDLE cycle.
REQ-025 SHALL leave state and count unchanged in RUN cycles with in_valid=0.
REQ-026 SHALL treat len=2^LEN_W-1 as the maximum; the counter never wraps within a frame.
REQ-027 SHALL, on abort=1 in RUN or OUT: return to IDLE next cycle with no out_valid and no nibble accepted that cycle; abort has priority over all handshakes.
REQ-028 SHALL ignore abort in IDLE.
REQ-029 SHALL hold count at its final value through OUT and clear it only on the next accepted start.

Reset
REQ-030 SHALL, on reset=1 at a rising clk: go to IDLE and set accumulator=0, count=0, in_ready=0, out_valid=0, parity=0, busy=0, latched odd=0.
REQ-031 SHALL give reset priority over abort, start and all handshakes; reset mid-frame discards the frame.

Structure
REQ-032 SHALL place the FSM state enum (IDLE, RUN, OUT) and the LEN_W default in shared package parity_pkg.
REQ-033 SHALL instantiate one sub-module, nibble_parity: combinational 4-bit XOR reduce, input 4 bits, output 1 bit.

Verification
REQ-034 SHALL cover: len=3, odd=0, nibbles 0001, 0011, 0111 back-to-back -> out_valid 1 cycle after the 3rd accept, parity=0, count=3.
REQ-035 SHALL cover: the REQ-034 frame with odd=1 -> parity=1.
REQ-036 SHALL cover: len=0, odd=1 -> out_valid the cycle after start, parity=1, count=0, in_ready never asserted.
REQ-037 SHALL cover: len=2, nibbles 1000, 0000 with 3 idle in_valid=0 cycles between them, out_ready held low for 5 cycles -> out_valid and parity=1 held stable, IDLE the cycle after out_ready=1.
REQ-038 SHALL cover: len=4 frame aborted after 2 accepts -> IDLE next cycle, no out_valid; a following len=1, data 1111 frame -> parity=0.
REQ-039 SHALL cover: reset asserted in OUT -> all outputs zero next cycle; start held high during the OUT handshake is not accepted.
